// File: rtl/ysyx_210238_mdu.sv
// ysyx_210238_mdu -- iterative RV64M multiply/divide unit.
//
// Radix-2 shift-add multiply and radix-2 restoring divide, one bit per cycle.
// Operands are converted to magnitudes when accepted and the result sign is
// latched, so the iteration itself is always unsigned. *W ops run WLEN steps
// and sign-extend the low WLEN result bits. Divide-by-zero and signed overflow
// are resolved when the request is accepted and skip the iteration entirely.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready     request handshake (o_ready only in IDLE)
//   i_op, i_word          operation select (MUL..REMU) and *W variant
//   i_src1, i_src2        forwarded operands
//   i_rd_addr             destination register, returned with the result
//   i_flush               kill any in-flight op
//   o_valid / i_ready     result handshake
//   o_result, o_rd_addr   registered result and its destination register
//   o_busy                unit is not idle
module ysyx_210238_mdu #(
   parameter int XLEN = 64,
   parameter int WLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic            i_word,
   input  logic [XLEN-1:0] i_src1,
   input  logic [XLEN-1:0] i_src2,
   input  logic [4:0]      i_rd_addr,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result,
   output logic [4:0]      o_rd_addr,
   output logic            o_busy
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam int SH = XLEN - WLEN;
   localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(SH+1){1'b1}}, {(WLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] v);
      return {{SH{v[WLEN-1]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] zext_w(input logic [WLEN-1:0] v);
      return {{SH{1'b0}}, v};
   endfunction

   state_t          state, state_nxt;
   logic            accept, is_div;
   logic            s1_signed, s2_signed;
   logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;
   logic            neg_a, neg_b, div_zero, div_ovf, special;
   logic [XLEN-1:0] spec_raw, spec_res;

   // iteration state: {hi, lo} is the product accumulator for multiply and
   // {rem, quo} for divide; mcand is the multiplicand or the divisor
   logic [XLEN-1:0] hi, lo, mcand;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_q;
   logic            word_q, neg_q, rneg_q;
   logic [4:0]      rd_q;

   assign o_ready = (state == IDLE);
   assign o_busy  = (state != IDLE);
   assign accept  = i_valid & o_ready & ~i_flush;
   assign is_div  = i_op[2];

   // ---------------- operand preparation ----------------
   always_comb begin
      s1_signed = 1'b1;
      s2_signed = 1'b1;
      if (is_div) begin
         s1_signed = ~i_op[0];
         s2_signed = ~i_op[0];
      end else if (!i_word) begin
         // word multiplies all collapse to MULW, where signedness is moot
         case (i_op[1:0])
            2'd2: s2_signed = 1'b0;
            2'd3: begin
               s1_signed = 1'b0;
               s2_signed = 1'b0;
            end
            default: ;
         endcase
      end

      op_a = i_src1;
      op_b = i_src2;
      if (i_word) begin
         op_a = s1_signed ? sext_w(i_src1[WLEN-1:0]) : zext_w(i_src1[WLEN-1:0]);
         op_b = s2_signed ? sext_w(i_src2[WLEN-1:0]) : zext_w(i_src2[WLEN-1:0]);
      end

      neg_a = s1_signed & op_a[XLEN-1];
      neg_b = s2_signed & op_b[XLEN-1];
      mag_a = neg_a ? -op_a : op_a;
      mag_b = neg_b ? -op_b : op_b;

      div_zero = is_div & (op_b == '0);
      div_ovf  = is_div & ~i_op[0] & (op_a == (i_word ? MIN_W : MIN_X)) & (op_b == '1);
      special  = div_zero | div_ovf;

      // op[1] selects remainder; quotient is -1 on /0 and the dividend on overflow
      spec_raw = i_op[1] ? (div_zero ? op_a : '0) : (div_zero ? '1 : op_a);
      spec_res = i_word ? sext_w(spec_raw[WLEN-1:0]) : spec_raw;
   end

   // ---------------- one iteration step ----------------
   logic [XLEN:0]   add_sum, shl, sub_diff;
   logic [XLEN-1:0] hi_n, lo_n;

   always_comb begin
      add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      shl      = {hi, lo[XLEN-1]};
      // shl < 2*mcand, so the top bit of the difference is exactly the borrow
      sub_diff = shl - {1'b0, mcand};
      if (op_q[2]) begin
         hi_n = sub_diff[XLEN] ? shl[XLEN-1:0] : sub_diff[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], ~sub_diff[XLEN]};
      end else begin
         hi_n = add_sum[XLEN:1];
         lo_n = {add_sum[0], lo[XLEN-1:1]};
      end
   end

   // ---------------- result assembly after the last step ----------------
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo_s, rem_s, fin_raw, fin_res;
   logic [WLEN-1:0]   fin_w;

   always_comb begin
      prod = {hi_n, lo_n};
      if (neg_q) prod = -prod;
      quo_s = neg_q  ? -lo_n : lo_n;
      rem_s = rneg_q ? -hi_n : hi_n;
      if (op_q[2])                fin_raw = op_q[1] ? rem_s : quo_s;
      else if (op_q[1:0] == 2'd0) fin_raw = prod[XLEN-1:0];
      else                        fin_raw = prod[2*XLEN-1:XLEN];
      // after only WLEN right shifts the word product sits SH bits up
      fin_w   = op_q[2] ? fin_raw[WLEN-1:0] : prod[SH +: WLEN];
      fin_res = word_q ? sext_w(fin_w) : fin_raw;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = special ? DONE : CALC;
         CALC:    if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    if (i_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (i_flush) state_nxt = IDLE;
   end

   // ---------------- datapath / output registers ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hi        <= '0;
         lo        <= '0;
         mcand     <= '0;
         cnt       <= '0;
         op_q      <= '0;
         word_q    <= 1'b0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
         rd_q      <= '0;
         o_valid   <= 1'b0;
         o_result  <= '0;
         o_rd_addr <= '0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_q   <= i_op;
               word_q <= i_word;
               rd_q   <= i_rd_addr;
               neg_q  <= neg_a ^ neg_b;
               rneg_q <= neg_a;
               cnt    <= i_word ? CW'(WLEN) : CW'(XLEN);
               hi     <= '0;
               if (is_div) begin
                  // word dividend is pre-aligned so its MSB is shifted out first
                  lo    <= i_word ? (mag_a << SH) : mag_a;
                  mcand <= mag_b;
               end else begin
                  lo    <= mag_b;
                  mcand <= mag_a;
               end
               if (special) begin
                  o_valid   <= 1'b1;
                  o_result  <= spec_res;
                  o_rd_addr <= i_rd_addr;
               end
            end
            CALC: begin
               hi  <= hi_n;
               lo  <= lo_n;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  o_valid   <= 1'b1;
                  o_result  <= fin_res;
                  o_rd_addr <= rd_q;
               end
            end
            DONE: if (i_ready) o_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_210238_mdu.sv
// Self-checking bench for ysyx_210238_mdu: a one-entry behavioural model of
// the unit is compared against the DUT on every cycle, with directed literal
// cases and randomized operations driven through it.
module tb_ysyx_210238_mdu;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_op;
   logic        i_word;
   logic [63:0] i_src1, i_src2;
   logic [4:0]  i_rd_addr;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [63:0] o_result;
   logic [4:0]  o_rd_addr;
   logic        o_busy;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   // model of the single in-flight operation
   bit          m_busy = 1'b0;
   logic [63:0] m_res  = '0;
   logic [4:0]  m_rd   = '0;
   int          m_lat  = 0;
   int          m_age  = 0;

   ysyx_210238_mdu #(.XLEN(64), .WLEN(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_word(i_word), .i_src1(i_src1), .i_src2(i_src2),
      .i_rd_addr(i_rd_addr), .i_flush(i_flush), .o_valid(o_valid),
      .i_ready(i_ready), .o_result(o_result), .o_rd_addr(o_rd_addr),
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // RISC-V M-extension semantics in plain arithmetic
   function automatic logic [63:0] model(input logic [2:0] op, input logic word,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [31:0]  a32, b32, r32;
      logic [63:0]  r;
      bit           ovf;
      p = '0;
      a32 = a[31:0];
      b32 = b[31:0];
      if (word) begin
         ovf = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
         case (op)
            3'd4:    r32 = (b32 == 0) ? 32'hFFFF_FFFF : ovf ? a32 : 32'(int'(a32) / int'(b32));
            3'd5:    r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
            3'd6:    r32 = (b32 == 0) ? a32 : ovf ? 32'd0 : 32'(int'(a32) % int'(b32));
            3'd7:    r32 = (b32 == 0) ? a32 : a32 % b32;
            default: r32 = a32 * b32;
         endcase
         r = {{32{r32[31]}}, r32};
      end else begin
         ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
         case (op)
            3'd0: r = a * b;
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = 64'(p >> 64); end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = 64'(p >> 64); end
            3'd3: begin p = {64'd0, a} * {64'd0, b};             r = 64'(p >> 64); end
            3'd4: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? a : 64'(longint'(a) / longint'(b));
            3'd5: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 64'd0 : 64'(longint'(a) % longint'(b));
            default: r = (b == 0) ? a : a % b;
         endcase
      end
      return r;
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic word,
                                     input logic [63:0] a, input logic [63:0] b);
      if (!op[2]) return 1'b0;
      if (word)
         return (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      return (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 8))
         0:       return 64'd0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h8000_0000_0000_0000;
         3:       return {32'($urandom), 32'h8000_0000};
         4:       return 64'($urandom_range(0, 20));
         5:       return {32'hFFFF_FFFF, 32'($urandom)};
         6:       return {32'($urandom), 32'h0};
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   // compare process: outputs checked against the model every cycle
   initial begin
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            m_busy = 1'b0;
         end else begin
            check("busy", 64'(o_busy), 64'(m_busy));
            check("ready", 64'(o_ready), 64'(!m_busy));
            if (m_busy) begin
               m_age++;
               check("valid", 64'(o_valid), 64'(m_age >= m_lat));
               if (m_age >= m_lat && o_valid) begin
                  check("result", o_result, m_res);
                  check("rd_addr", 64'(o_rd_addr), 64'(m_rd));
               end
            end else begin
               check("valid_idle", 64'(o_valid), 64'd0);
            end
            if (i_flush) begin
               m_busy = 1'b0;
            end else if (m_busy && m_age >= m_lat && i_ready) begin
               m_busy = 1'b0;
            end else if (!m_busy && i_valid) begin
               m_busy = 1'b1;
               m_res  = model(i_op, i_word, i_src1, i_src2);
               m_rd   = i_rd_addr;
               m_age  = 0;
               m_lat  = is_special(i_op, i_word, i_src1, i_src2) ? 1 : (i_word ? 33 : 65);
            end
         end
      end
   end

   // called at posedge+1; returns at posedge+1 just after the accept edge
   task automatic issue(input logic [2:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
      bit ok = 1'b0;
      int n  = 0;
      i_valid = 1'b1; i_op = op; i_word = word; i_src1 = a; i_src2 = b; i_rd_addr = rd;
      while (!ok && n < 300) begin
         @(negedge i_clk);
         ok = o_ready;
         n++;
         @(posedge i_clk);
         #1;
      end
      i_valid   = 1'b0;
      i_src1    = {32'($urandom), 32'($urandom)};
      i_src2    = {32'($urandom), 32'($urandom)};
      i_rd_addr = 5'($urandom);
      if (!ok) begin
         tot_cnt++;
         $display("FAIL accept_timeout: o_ready low for %0d cycles", n);
      end
   endtask

   // waits for o_valid, holds i_ready low for 'hold' more cycles, then consumes
   task automatic collect(input int hold, output logic [63:0] res, output int lat);
      bit seen = 1'b0;
      logic [4:0] rd;
      lat = 0;
      res = '0;
      while (!seen && lat < 300) begin
         @(negedge i_clk);
         lat++;
         seen = o_valid;
      end
      if (!seen) begin
         tot_cnt++;
         $display("FAIL valid_timeout: o_valid low for %0d cycles", lat);
      end else begin
         res = o_result;
         rd  = o_rd_addr;
         for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            check("hold_result", o_result, res);
            check("hold_rd", 64'(o_rd_addr), 64'(rd));
            check("hold_ready", 64'(o_ready), 64'd0);
         end
         @(posedge i_clk); #1;
         i_ready = 1'b1;
         @(posedge i_clk); #1;
         i_ready = 1'b0;
      end
   endtask

   task automatic run(input logic [2:0] op, input logic word, input logic [63:0] a,
                      input logic [63:0] b, input int hold,
                      output logic [63:0] res, output int lat);
      issue(op, word, a, b, 5'($urandom));
      collect(hold, res, lat);
   endtask

   initial begin
      logic [63:0] res;
      int          lat;
      bit          seen;
      i_rst_n = 1'b1; i_valid = 1'b0; i_op = '0; i_word = 1'b0; i_src1 = '0;
      i_src2 = '0; i_rd_addr = '0; i_flush = 1'b0; i_ready = 1'b0;
      #1 i_rst_n = 1'b0;
      #1;
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_result", o_result, 64'd0);
      check("rst_rd", 64'(o_rd_addr), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      #20 i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // directed literal cases
      run(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, res, lat);
      check("mul_3x-5", res, 64'hFFFF_FFFF_FFFF_FFF1);
      check("mul_latency", 64'(lat), 64'd65);
      run(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, res, lat);
      check("mulhu_max", res, 64'hFFFF_FFFF_FFFF_FFFE);
      run(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, res, lat);
      check("mulh_-1x-1", res, 64'd0);
      run(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, res, lat);
      check("div_-7/2", res, 64'hFFFF_FFFF_FFFF_FFFD);
      run(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, res, lat);
      check("rem_-7/2", res, 64'hFFFF_FFFF_FFFF_FFFF);
      run(3'd4, 1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, res, lat);
      check("divw_ovf", res, 64'hFFFF_FFFF_8000_0000);
      check("divw_ovf_latency", 64'(lat), 64'd1);
      run(3'd5, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, res, lat);
      check("divu_by0", res, 64'hFFFF_FFFF_FFFF_FFFF);
      check("divu_by0_latency", 64'(lat), 64'd1);
      run(3'd7, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, res, lat);
      check("remu_by0", res, 64'h1234_5678_9ABC_DEF0);
      check("remu_by0_latency", 64'(lat), 64'd1);
      run(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, res, lat);
      check("div_ovf", res, 64'h8000_0000_0000_0000);
      run(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, res, lat);
      check("rem_ovf", res, 64'd0);

      // result held 5 cycles while downstream stalls
      run(3'd5, 1'b0, 64'd100, 64'd7, 5, res, lat);
      check("divu_hold", res, 64'd14);

      // flush in the middle of CALC
      issue(3'd0, 1'b0, 64'd123, 64'd456, 5'd3);
      repeat (9) @(posedge i_clk);
      #1 i_flush = 1'b1;
      @(posedge i_clk); #1 i_flush = 1'b0;
      @(negedge i_clk);
      check("flush_ready", 64'(o_ready), 64'd1);
      seen = 1'b0;
      repeat (70) begin
         @(negedge i_clk);
         if (o_valid) seen = 1'b1;
      end
      check("flush_no_valid", 64'(seen), 64'd0);
      @(posedge i_clk); #1;
      run(3'd0, 1'b0, 64'd6, 64'd7, 0, res, lat);
      check("mul_6x7", res, 64'd42);

      // asynchronous reset during CALC
      issue(3'd0, 1'b0, 64'hDEAD_BEEF, 64'h1234, 5'd9);
      repeat (20) @(posedge i_clk);
      #3 i_rst_n = 1'b0;
      #1;
      check("rst_calc_valid", 64'(o_valid), 64'd0);
      check("rst_calc_result", o_result, 64'd0);
      check("rst_calc_rd", 64'(o_rd_addr), 64'd0);
      check("rst_calc_busy", 64'(o_busy), 64'd0);
      @(posedge i_clk); #2 i_rst_n = 1'b1;
      @(negedge i_clk);
      check("rst_release_ready", 64'(o_ready), 64'd1);
      @(posedge i_clk); #1;

      // randomized operations
      for (int k = 0; k < 150; k++) begin
         run(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), pick(), pick(),
             $urandom_range(0, 3), res, lat);
         repeat ($urandom_range(0, 2)) @(posedge i_clk);
         #1;
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #800000;
      tot_cnt++;
      $display("FAIL watchdog: simulation did not complete");
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
